// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - instruction handshake and datapath control bundle
interface mips_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        iszero;
  logic        mem_ready;
  logic [4:0]  alu_control;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUsrc;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic        done;
  logic        branch_taken;
  logic        err;

  // master: instruction source / datapath side
  modport master (
    output instr, instr_valid, iszero, mem_ready,
    input  instr_ready, alu_control, RegDst, RegWrite, ALUsrc,
           MemWrite, MemRead, MemToReg, done, branch_taken, err
  );

  // slave: the control unit
  modport slave (
    input  instr, instr_valid, iszero, mem_ready,
    output instr_ready, alu_control, RegDst, RegWrite, ALUsrc,
           MemWrite, MemRead, MemToReg, done, branch_taken, err
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM (DECODE/EXEC/MEM/WB)
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  mips_multicycle_ctrl_if.slave    ctrl_if
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam int              WW        = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;

  logic [2:0]    state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [5:0]    funct_q, funct_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          done_q, done_d;
  logic          bt_q, bt_d;
  logic          err_q, err_d;

  logic       is_r, is_lw, is_sw, is_beq, is_addi, legal;
  logic       funct_ok;
  logic [4:0] r_alu;

  // Only opcode and funct steer control; register fields belong to the datapath.
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct_q)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h2A:   r_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  assign is_r    = (op_q == 6'h00) && funct_ok;
  assign is_lw   = (op_q == 6'h23);
  assign is_sw   = (op_q == 6'h2B);
  assign is_beq  = (op_q == 6'h04);
  assign is_addi = (op_q == 6'h08);
  assign legal   = is_r | is_lw | is_sw | is_beq | is_addi;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    bt_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_if.instr_valid) begin
          op_d    = ctrl_if.instr[31:26];
          funct_d = ctrl_if.instr[5:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (is_beq) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          bt_d    = ctrl_if.iszero;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // mem_ready in the final allowed cycle still wins over the timeout.
        if (ctrl_if.mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      funct_q <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      bt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      bt_q    <= bt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ctrl_if.instr_ready  = (state_q == S_IDLE);
    ctrl_if.alu_control  = ALU_ADD;
    ctrl_if.RegDst       = 1'b0;
    ctrl_if.RegWrite     = 1'b0;
    ctrl_if.ALUsrc       = 1'b0;
    ctrl_if.MemWrite     = 1'b0;
    ctrl_if.MemRead      = 1'b0;
    ctrl_if.MemToReg     = 1'b0;
    ctrl_if.done         = done_q;
    ctrl_if.branch_taken = bt_q;
    ctrl_if.err          = err_q;
    case (state_q)
      S_EXEC: begin
        ctrl_if.alu_control = is_beq ? ALU_SUB : (is_r ? r_alu : ALU_ADD);
        ctrl_if.ALUsrc      = is_lw | is_sw | is_addi;
      end
      S_MEM: begin
        ctrl_if.ALUsrc   = 1'b1;
        ctrl_if.MemRead  = is_lw;
        ctrl_if.MemWrite = is_sw;
      end
      S_WB: begin
        ctrl_if.RegWrite = 1'b1;
        ctrl_if.RegDst   = is_r;
        ctrl_if.MemToReg = is_lw;
      end
      default: ;
    endcase
  end

endmodule
